// File: rtl/cpu_regfile_mp.sv
// ---------------------------------------------------------------------------
// cpu_regfile_mp
//   Integer register file with two read ports, two write ports and a
//   per-register busy scoreboard for long-latency results.
//
//   Parameters
//     XLEN      register width (32 or 64)
//     NUM_REGS  architectural registers (16 or 32), x0 hardwired to zero
//     BYPASS    1: same-cycle write data/busy-clear forwarded to read ports
//               0: reads see stored state only
//
//   Ports
//     clk, reset                         clock, synchronous active-high reset
//     rs1_addr/rs2_addr                  read addresses
//     rs1_data/rs2_data                  combinational read data
//     rs1_busy/rs2_busy                  combinational busy flag of read reg
//     wr0_en/wr0_addr/wr0_data           write port 0 (single-cycle results)
//     wr1_en/wr1_addr/wr1_data           write port 1 (long-latency results,
//                                        also clears the target busy bit)
//     busy_set_en/busy_set_addr          mark a register pending on port 1
//     busy_any                           OR of all busy bits
// ---------------------------------------------------------------------------
module cpu_regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int BYPASS   = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            wr0_en,
    input  logic [4:0]      wr0_addr,
    input  logic [XLEN-1:0] wr0_data,
    input  logic            wr1_en,
    input  logic [4:0]      wr1_addr,
    input  logic [XLEN-1:0] wr1_data,
    input  logic            busy_set_en,
    input  logic [4:0]      busy_set_addr,
    output logic            busy_any
);

    localparam int         IDX_W     = $clog2(NUM_REGS);
    localparam logic [5:0] REG_LIMIT = 6'(NUM_REGS);

    logic [XLEN-1:0]     regs_reg [NUM_REGS];
    logic [NUM_REGS-1:0] busy_reg;

    // One-hot decode of each write/set request. Entry 0 is never selected,
    // and addresses >= NUM_REGS match no entry, so illegal requests drop out.
    logic [NUM_REGS-1:0] wr0_hit;
    logic [NUM_REGS-1:0] wr1_hit;
    logic [NUM_REGS-1:0] set_hit;

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_dec
        if (gi == 0) begin : g_zero
            assign wr0_hit[gi] = 1'b0;
            assign wr1_hit[gi] = 1'b0;
            assign set_hit[gi] = 1'b0;
        end else begin : g_reg
            assign wr0_hit[gi] = wr0_en      && (wr0_addr      == 5'(gi));
            assign wr1_hit[gi] = wr1_en      && (wr1_addr      == 5'(gi));
            assign set_hit[gi] = busy_set_en && (busy_set_addr == 5'(gi));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_reg[i] <= '0;
            end
            busy_reg <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                // Port 0 wins a same-address collision on data.
                if (wr0_hit[i]) begin
                    regs_reg[i] <= wr0_data;
                end else if (wr1_hit[i]) begin
                    regs_reg[i] <= wr1_data;
                end
                // A newly issued op outranks the completion of the old one.
                if (set_hit[i]) begin
                    busy_reg[i] <= 1'b1;
                end else if (wr1_hit[i]) begin
                    busy_reg[i] <= 1'b0;
                end
            end
        end
    end

    assign busy_any = |busy_reg;

    // Read ports: identical logic replicated for rs1 (0) and rs2 (1).
    logic [4:0] rd_addr [2];
    assign rd_addr[0] = rs1_addr;
    assign rd_addr[1] = rs2_addr;

    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
        logic             legal;
        logic [IDX_W-1:0] idx;
        logic             byp0;
        logic             byp1;
        logic             set_same;
        logic [XLEN-1:0]  data;
        logic             busy;

        assign legal    = (rd_addr[gi] != 5'd0) && ({1'b0, rd_addr[gi]} < REG_LIMIT);
        assign idx      = rd_addr[gi][IDX_W-1:0];
        assign byp0     = (BYPASS != 0) && wr0_en && (wr0_addr == rd_addr[gi]);
        assign byp1     = (BYPASS != 0) && wr1_en && (wr1_addr == rd_addr[gi]);
        assign set_same = busy_set_en && (busy_set_addr == rd_addr[gi]);

        always_comb begin
            data = '0;
            busy = 1'b0;
            if (legal) begin
                if (byp0) begin
                    data = wr0_data;
                end else if (byp1) begin
                    data = wr1_data;
                end else begin
                    data = regs_reg[idx];
                end
                // A completing port-1 write hides the stale busy bit, unless
                // the same register is being re-issued this cycle.
                busy = (byp1 && !set_same) ? 1'b0 : busy_reg[idx];
            end
        end
    end

    assign rs1_data = g_rd[0].data;
    assign rs2_data = g_rd[1].data;
    assign rs1_busy = g_rd[0].busy;
    assign rs2_busy = g_rd[1].busy;

endmodule

// File: tb/tb_cpu_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_cpu_regfile_mp
//   Self-checking bench for cpu_regfile_mp. Instance "dut" uses the default
//   configuration (XLEN=32, NUM_REGS=32, BYPASS=1); instance "dutb" uses
//   XLEN=64, NUM_REGS=16, BYPASS=0. Expected values are queued when stimulus
//   is applied and popped when the outputs are sampled.
// ---------------------------------------------------------------------------
module tb_cpu_regfile_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // default-configuration instance
    logic [4:0]  rs1_addr, rs2_addr, wr0_addr, wr1_addr, busy_set_addr;
    logic [31:0] rs1_data, rs2_data, wr0_data, wr1_data;
    logic        rs1_busy, rs2_busy, wr0_en, wr1_en, busy_set_en, busy_any;

    // 64-bit / 16-register / no-bypass instance
    logic [4:0]  b_rs1_addr, b_rs2_addr, b_wr0_addr, b_wr1_addr, b_busy_set_addr;
    logic [63:0] b_rs1_data, b_rs2_data, b_wr0_data, b_wr1_data;
    logic        b_rs1_busy, b_rs2_busy, b_wr0_en, b_wr1_en, b_busy_set_en, b_busy_any;

    cpu_regfile_mp #(.XLEN(32), .NUM_REGS(32), .BYPASS(1)) dut (
        .clk(clk), .reset(reset),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .busy_set_en(busy_set_en), .busy_set_addr(busy_set_addr),
        .busy_any(busy_any)
    );

    cpu_regfile_mp #(.XLEN(64), .NUM_REGS(16), .BYPASS(0)) dutb (
        .clk(clk), .reset(reset),
        .rs1_addr(b_rs1_addr), .rs2_addr(b_rs2_addr),
        .rs1_data(b_rs1_data), .rs2_data(b_rs2_data),
        .rs1_busy(b_rs1_busy), .rs2_busy(b_rs2_busy),
        .wr0_en(b_wr0_en), .wr0_addr(b_wr0_addr), .wr0_data(b_wr0_data),
        .wr1_en(b_wr1_en), .wr1_addr(b_wr1_addr), .wr1_data(b_wr1_data),
        .busy_set_en(b_busy_set_en), .busy_set_addr(b_busy_set_addr),
        .busy_any(b_busy_any)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [63:0] sb [$];
    logic [63:0] exp_val;

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // 4 units later, well before the next edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic idle();
        wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
        wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
        busy_set_en = 1'b0; busy_set_addr = '0;
        b_wr0_en = 1'b0; b_wr0_addr = '0; b_wr0_data = '0;
        b_wr1_en = 1'b0; b_wr1_addr = '0; b_wr1_data = '0;
        b_busy_set_en = 1'b0; b_busy_set_addr = '0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        rs1_addr = 5'd9; rs2_addr = 5'd0; b_rs1_addr = 5'd9; b_rs2_addr = 5'd0;
        // writes and busy sets issued under reset must not be retained
        wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'hCAFE0009;
        busy_set_en = 1'b1; busy_set_addr = 5'd9;
        b_wr0_en = 1'b1; b_wr0_addr = 5'd9; b_wr0_data = 64'hCAFE;
        cycle(); cycle();
        reset = 1'b0;
        idle();
        sb.push_back(64'h0); sb.push_back(64'h0); sb.push_back(64'h0); sb.push_back(64'h0);
        settle();
        exp_val = sb.pop_front(); n_checks++; if (64'(rs1_data) !== exp_val) $display("FAIL reset_x9_data got %h want %h", rs1_data, exp_val); else begin n_pass++; $display("ok reset_x9_data %h", rs1_data); end
        exp_val = sb.pop_front(); n_checks++; if (64'(rs1_busy) !== exp_val) $display("FAIL reset_x9_busy got %b want %0h", rs1_busy, exp_val); else begin n_pass++; $display("ok reset_x9_busy %b", rs1_busy); end
        exp_val = sb.pop_front(); n_checks++; if (64'(busy_any) !== exp_val) $display("FAIL reset_busy_any got %b want %0h", busy_any, exp_val); else begin n_pass++; $display("ok reset_busy_any %b", busy_any); end
        exp_val = sb.pop_front(); n_checks++; if (b_rs1_data !== exp_val) $display("FAIL reset_b_x9_data got %h want %h", b_rs1_data, exp_val); else begin n_pass++; $display("ok reset_b_x9_data %h", b_rs1_data); end
        cycle();
    endtask

    task automatic test_basic();
        wr0_en = 1'b1; wr0_addr = 5'd1; wr0_data = 32'h12345678;
        sb.push_back(64'h12345678); sb.push_back(64'h0);
        cycle();
        idle();
        rs1_addr = 5'd1; rs2_addr = 5'd2;
        settle();
        exp_val = sb.pop_front(); n_checks++; if (64'(rs1_data) !== exp_val) $display("FAIL basic_x1 got %h want %h", rs1_data, exp_val); else begin n_pass++; $display("ok basic_x1 %h", rs1_data); end
        exp_val = sb.pop_front(); n_checks++; if (64'(rs2_data) !== exp_val) $display("FAIL basic_x2 got %h want %h", rs2_data, exp_val); else begin n_pass++; $display("ok basic_x2 %h", rs2_data); end
        cycle();
    endtask

    task automatic test_x0_and_collision();
        // both ports at x0: no bypass, no storage, never busy
        wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'hDEADBEEF;
        wr1_en = 1'b1; wr1_addr = 5'd0; wr1_data = 32'hDEADBEEF;
        busy_set_en = 1'b1; busy_set_addr = 5'd0;
        rs1_addr = 5'd0;
        sb.push_back(64'h0); sb.push_back(64'h0);
        settle();
        exp_val = sb.pop_front(); n_checks++; if (64'(rs1_data) !== exp_val) $display("FAIL x0_bypass got %h want %h", rs1_data, exp_val); else begin n_pass++; $display("ok x0_bypass %h", rs1_data); end
        cycle();
        idle();
        settle();
        exp_val = sb.pop_front(); n_checks++; if (64'({rs1_data, rs1_busy, busy_any}) !== exp_val) $display("FAIL x0_stored got %h/%b/%b want 0", rs1_data, rs1_busy, busy_any); else begin n_pass++; $display("ok x0_stored %h", rs1_data); end
        cycle();
        // mark x5 busy, then collide both write ports on x5
        busy_set_en = 1'b1; busy_set_addr = 5'd5;
        cycle();
        idle();
        wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'h55555555;
        wr1_en = 1'b1; wr1_addr = 5'd5; wr1_data = 32'hAAAAAAAA;
        sb.push_back(64'h55555555); sb.push_back(64'h0);
        cycle();
        idle();
        rs1_addr = 5'd5;
        settle();
        exp_val = sb.pop_front(); n_checks++; if (64'(rs1_data) !== exp_val) $display("FAIL collide_data got %h want %h", rs1_data, exp_val); else begin n_pass++; $display("ok collide_data %h", rs1_data); end
        exp_val = sb.pop_front(); n_checks++; if (64'(rs1_busy) !== exp_val) $display("FAIL collide_busy got %b want %0h", rs1_busy, exp_val); else begin n_pass++; $display("ok collide_busy %b", rs1_busy); end
        cycle();
    endtask

    task automatic test_bypass();
        wr1_en = 1'b1; wr1_addr = 5'd6; wr1_data = 32'hFFFFFFFF;
        rs1_addr = 5'd6;
        sb.push_back(64'hFFFFFFFF);
        settle();
        exp_val = sb.pop_front(); n_checks++; if (64'(rs1_data) !== exp_val) $display("FAIL bypass_wr1 got %h want %h", rs1_data, exp_val); else begin n_pass++; $display("ok bypass_wr1 %h", rs1_data); end
        cycle();
        idle();
        // port 0 outranks port 1 on the bypass path
        wr0_en = 1'b1; wr0_addr = 5'd10; wr0_data = 32'h11111111;
        wr1_en = 1'b1; wr1_addr = 5'd10; wr1_data = 32'h22222222;
        rs2_addr = 5'd10;
        sb.push_back(64'h11111111);
        settle();
        exp_val = sb.pop_front(); n_checks++; if (64'(rs2_data) !== exp_val) $display("FAIL bypass_prio got %h want %h", rs2_data, exp_val); else begin n_pass++; $display("ok bypass_prio %h", rs2_data); end
        cycle();
        idle();
        // different addresses on the two ports both commit
        wr0_en = 1'b1; wr0_addr = 5'd11; wr0_data = 32'hA0A0A0A0;
        wr1_en = 1'b1; wr1_addr = 5'd12; wr1_data = 32'hB1B1B1B1;
        sb.push_back(64'hA0A0A0A0); sb.push_back(64'hB1B1B1B1);
        cycle();
        idle();
        rs1_addr = 5'd11; rs2_addr = 5'd12;
        settle();
        exp_val = sb.pop_front(); n_checks++; if (64'(rs1_data) !== exp_val) $display("FAIL dual_x11 got %h want %h", rs1_data, exp_val); else begin n_pass++; $display("ok dual_x11 %h", rs1_data); end
        exp_val = sb.pop_front(); n_checks++; if (64'(rs2_data) !== exp_val) $display("FAIL dual_x12 got %h want %h", rs2_data, exp_val); else begin n_pass++; $display("ok dual_x12 %h", rs2_data); end
        cycle();
    endtask

    task automatic test_busy();
        busy_set_en = 1'b1; busy_set_addr = 5'd7;
        cycle();
        idle();
        rs2_addr = 5'd7;
        sb.push_back(64'h3);
        settle();
        exp_val = sb.pop_front(); n_checks++; if (64'({rs2_busy, busy_any}) !== exp_val) $display("FAIL busy_set got %b/%b want 1/1", rs2_busy, busy_any); else begin n_pass++; $display("ok busy_set %b", rs2_busy); end
        // completion and re-issue together: still busy, data lands
        wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h0BADF00D;
        busy_set_en = 1'b1; busy_set_addr = 5'd7;
        sb.push_back(64'h1); sb.push_back(64'h1_0BADF00D);
        settle();
        exp_val = sb.pop_front(); n_checks++; if (64'(rs2_busy) !== exp_val) $display("FAIL busy_reissue_comb got %b want %0h", rs2_busy, exp_val); else begin n_pass++; $display("ok busy_reissue_comb %b", rs2_busy); end
        cycle();
        idle();
        settle();
        exp_val = sb.pop_front(); n_checks++; if ({31'd0, rs2_busy, rs2_data} !== exp_val) $display("FAIL busy_reissue_reg got %b/%h want %h", rs2_busy, rs2_data, exp_val); else begin n_pass++; $display("ok busy_reissue_reg %h", rs2_data); end
        // plain completion: busy hidden in the same cycle, cleared after
        wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h00C0FFEE;
        sb.push_back(64'h0); sb.push_back(64'h0);
        settle();
        exp_val = sb.pop_front(); n_checks++; if (64'(rs2_busy) !== exp_val) $display("FAIL busy_clear_comb got %b want %0h", rs2_busy, exp_val); else begin n_pass++; $display("ok busy_clear_comb %b", rs2_busy); end
        cycle();
        idle();
        settle();
        exp_val = sb.pop_front(); n_checks++; if (64'({rs2_busy, busy_any}) !== exp_val) $display("FAIL busy_clear_reg got %b/%b want 0/0", rs2_busy, busy_any); else begin n_pass++; $display("ok busy_clear_reg %b", busy_any); end
        // port-0 writes leave busy bits alone
        busy_set_en = 1'b1; busy_set_addr = 5'd13;
        cycle();
        idle();
        wr0_en = 1'b1; wr0_addr = 5'd13; wr0_data = 32'h13131313;
        cycle();
        idle();
        rs1_addr = 5'd13;
        sb.push_back(64'h1_13131313);
        settle();
        exp_val = sb.pop_front(); n_checks++; if ({31'd0, rs1_busy, rs1_data} !== exp_val) $display("FAIL busy_wr0_keep got %b/%h want %h", rs1_busy, rs1_data, exp_val); else begin n_pass++; $display("ok busy_wr0_keep %h", rs1_data); end
        cycle();
    endtask

    task automatic test_reset_mid();
        busy_set_en = 1'b1; busy_set_addr = 5'd3;
        cycle();
        idle();
        wr0_en = 1'b1; wr0_addr = 5'd4; wr0_data = 32'hAAAAAAAA;
        cycle();
        idle();
        reset = 1'b1;
        busy_set_en = 1'b1; busy_set_addr = 5'd8;
        cycle();
        reset = 1'b0;
        idle();
        rs1_addr = 5'd3; rs2_addr = 5'd4;
        sb.push_back(64'h0); sb.push_back(64'h0); sb.push_back(64'h0);
        settle();
        exp_val = sb.pop_front(); n_checks++; if (64'(rs1_busy) !== exp_val) $display("FAIL mid_reset_x3_busy got %b want %0h", rs1_busy, exp_val); else begin n_pass++; $display("ok mid_reset_x3_busy %b", rs1_busy); end
        exp_val = sb.pop_front(); n_checks++; if (64'(rs2_data) !== exp_val) $display("FAIL mid_reset_x4 got %h want %h", rs2_data, exp_val); else begin n_pass++; $display("ok mid_reset_x4 %h", rs2_data); end
        exp_val = sb.pop_front(); n_checks++; if (64'(busy_any) !== exp_val) $display("FAIL mid_reset_busy_any got %b want %0h", busy_any, exp_val); else begin n_pass++; $display("ok mid_reset_busy_any %b", busy_any); end
        // a late completion for the flushed op writes data, busy stays clear
        wr1_en = 1'b1; wr1_addr = 5'd3; wr1_data = 32'h33333333;
        sb.push_back(64'h0_33333333);
        cycle();
        idle();
        settle();
        exp_val = sb.pop_front(); n_checks++; if ({31'd0, rs1_busy, rs1_data} !== exp_val) $display("FAIL late_wr1 got %b/%h want %h", rs1_busy, rs1_data, exp_val); else begin n_pass++; $display("ok late_wr1 %h", rs1_data); end
        cycle();
    endtask

    task automatic test_cfg_b();
        // x17 is outside a 16-register file
        b_wr0_en = 1'b1; b_wr0_addr = 5'd17; b_wr0_data = 64'h1;
        b_busy_set_en = 1'b1; b_busy_set_addr = 5'd17;
        sb.push_back(64'h0); sb.push_back(64'h0);
        cycle();
        idle();
        b_rs1_addr = 5'd17;
        settle();
        exp_val = sb.pop_front(); n_checks++; if (b_rs1_data !== exp_val) $display("FAIL b_x17 got %h want %h", b_rs1_data, exp_val); else begin n_pass++; $display("ok b_x17 %h", b_rs1_data); end
        exp_val = sb.pop_front(); n_checks++; if (64'(b_busy_any) !== exp_val) $display("FAIL b_x17_busy_any got %b want %0h", b_busy_any, exp_val); else begin n_pass++; $display("ok b_x17_busy_any %b", b_busy_any); end
        // full 64-bit width and the top legal register
        b_wr0_en = 1'b1; b_wr0_addr = 5'd8; b_wr0_data = 64'h123456789ABCDEF0;
        b_wr1_en = 1'b1; b_wr1_addr = 5'd15; b_wr1_data = 64'hF0E1D2C3B4A59687;
        sb.push_back(64'h123456789ABCDEF0); sb.push_back(64'hF0E1D2C3B4A59687);
        cycle();
        idle();
        b_rs1_addr = 5'd8; b_rs2_addr = 5'd15;
        settle();
        exp_val = sb.pop_front(); n_checks++; if (b_rs1_data !== exp_val) $display("FAIL b_x8_64 got %h want %h", b_rs1_data, exp_val); else begin n_pass++; $display("ok b_x8_64 %h", b_rs1_data); end
        exp_val = sb.pop_front(); n_checks++; if (b_rs2_data !== exp_val) $display("FAIL b_x15 got %h want %h", b_rs2_data, exp_val); else begin n_pass++; $display("ok b_x15 %h", b_rs2_data); end
        // no bypass: old value this cycle, new value after the edge
        b_wr1_en = 1'b1; b_wr1_addr = 5'd6; b_wr1_data = 64'hFFFFFFFF;
        b_rs1_addr = 5'd6;
        sb.push_back(64'h0); sb.push_back(64'hFFFFFFFF);
        settle();
        exp_val = sb.pop_front(); n_checks++; if (b_rs1_data !== exp_val) $display("FAIL b_nobypass_old got %h want %h", b_rs1_data, exp_val); else begin n_pass++; $display("ok b_nobypass_old %h", b_rs1_data); end
        cycle();
        idle();
        settle();
        exp_val = sb.pop_front(); n_checks++; if (b_rs1_data !== exp_val) $display("FAIL b_nobypass_new got %h want %h", b_rs1_data, exp_val); else begin n_pass++; $display("ok b_nobypass_new %h", b_rs1_data); end
        cycle();
    endtask

    initial begin
        reset = 1'b1;
        rs1_addr = '0; rs2_addr = '0; b_rs1_addr = '0; b_rs2_addr = '0;
        idle();
        #1;
        test_reset();
        test_basic();
        test_x0_and_collision();
        test_bypass();
        test_busy();
        test_reset_mid();
        test_cfg_b();
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain got %0d left want 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
